// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
package fifo_pkg;

  localparam int FIFO_DATA_W = 16;

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    FLUSH_WAIT = 2'd1,
    FLUSH_EMIT = 2'd2
  } pack_state_e;

  // Bits needed for a counter spanning 0..max_cnt inclusive.
  function automatic int lane_cnt_w(input int max_cnt);
    return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_out_reg.sv
// Valid/ready output holding register for packed beats (data + keep).
module fifo_rd_out_reg #(
  parameter int DW = 32,
  parameter int KW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic [KW-1:0] load_keep,
  output logic          can_load,
  output logic [DW-1:0] m_data,
  output logic [KW-1:0] m_keep,
  output logic          m_valid,
  input  logic          m_ready
);

  assign can_load = !m_valid || m_ready;

  // Data and keep only change on load, so they hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data  <= '0;
      m_keep  <= '0;
      m_valid <= 1'b0;
    end else if (load) begin
      m_data  <= load_data;
      m_keep  <= load_keep;
      m_valid <= 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains a FIFO with credit-checked reads and packs RATIO words per output beat.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int IN_W   = FIFO_DATA_W,
  parameter int RATIO  = 2,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [IN_W-1:0]       fifo_data_out,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic [IN_W*RATIO-1:0] m_data,
  output logic [RATIO-1:0]      m_keep,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  underflow_err
);

  localparam int CW = lane_cnt_w(RATIO);

  pack_state_e                  state;
  logic [CW-1:0]                lanes;
  logic [CW-1:0]                inflight;
  logic [CW-1:0]                lanes_eff;
  logic [RD_LAT-1:0]            vld_pipe;
  logic [RATIO-1:0][IN_W-1:0]   lane_q;
  logic [RATIO-1:0][IN_W-1:0]   load_data;
  logic [RATIO-1:0]             load_keep;
  logic                         flush_pend, land, can_load, xfer, emit, load;

  assign inflight   = CW'($countones(vld_pipe));
  assign flush_pend = (state != FILL);
  assign land       = vld_pipe[RD_LAT-1];
  assign xfer       = (lanes == CW'(RATIO)) && can_load;
  assign emit       = (state == FLUSH_EMIT) && can_load;
  assign load       = xfer || emit;

  // A full assembly leaving this cycle frees its lanes for an immediate re-read.
  assign lanes_eff  = xfer ? '0 : lanes;
  assign fifo_rd_en = !rst && !fifo_empty && !flush_pend &&
                      ((int'(lanes_eff) + int'(inflight)) < RATIO);

  assign busy = (lanes != '0) || (inflight != '0) || m_valid || flush_pend;

  // Lanes below the count are kept; the rest go out as zero.
  always_comb begin
    load_keep = '0;
    load_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      load_keep[i] = xfer || (CW'(i) < lanes);
      load_data[i] = load_keep[i] ? lane_q[i] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FILL;
      lanes         <= '0;
      vld_pipe      <= '0;
      lane_q        <= '0;
      underflow_err <= 1'b0;
    end else begin
      vld_pipe <= RD_LAT'({vld_pipe, fifo_rd_en});
      if (fifo_underflow) underflow_err <= 1'b1;

      if (land) begin
        for (int i = 0; i < RATIO; i++)
          if (lanes == CW'(i)) lane_q[i] <= fifo_data_out;
      end

      if (load)      lanes <= '0;
      else if (land) lanes <= lanes + CW'(1);

      case (state)
        FILL:       if (flush) state <= FLUSH_WAIT;
        // A full assembly drains through the normal path before deciding.
        FLUSH_WAIT: if (inflight == '0 && lanes != CW'(RATIO))
                      state <= (lanes == '0) ? FILL : FLUSH_EMIT;
        FLUSH_EMIT: if (can_load) state <= FILL;
        default:    state <= FILL;
      endcase
    end
  end

  fifo_rd_out_reg #(.DW(IN_W*RATIO), .KW(RATIO)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_keep (load_keep),
    .can_load  (can_load),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  a_credit: assert property (@(posedge clk) disable iff (rst)
    (int'(lanes) + int'(inflight)) <= RATIO);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench: per-cycle vector tables plus multi-cycle corner sequences.
module tb_fifo_rd_packer;

  typedef struct packed {
    logic        fl;
    logic        rdy;
    logic        rd;
    logic        mv;
    logic [31:0] d;
    logic [1:0]  k;
    logic        bz;
  } vec_t;

  logic clk, rst, fifo_underflow;
  logic flush1, m_ready1, rd_en1, mv1, busy1, uf_err1, fifo_empty1;
  logic [15:0] d1;
  logic [31:0] m_data1;
  logic [1:0]  m_keep1;
  logic flush2, m_ready2, rd_en2, mv2, busy2, uf_err2, fifo_empty2, uf2;
  logic [15:0] d2a, d2;
  logic [63:0] m_data2;
  logic [3:0]  m_keep2;

  logic [15:0] fq1[$];
  logic [15:0] fq2[$];
  int push_cnt1, pop_cnt1, push_cnt2, pop_cnt2;
  int errors, checks;
  vec_t t1[$];
  vec_t t3[$];
  vec_t t4[$];

  assign fifo_empty1 = (push_cnt1 == pop_cnt1);
  assign fifo_empty2 = (push_cnt2 == pop_cnt2);

  fifo_rd_packer #(.IN_W(16), .RATIO(2), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty1), .fifo_underflow(fifo_underflow),
    .fifo_data_out(d1), .fifo_rd_en(rd_en1), .flush(flush1), .m_data(m_data1),
    .m_keep(m_keep1), .m_valid(mv1), .m_ready(m_ready1), .busy(busy1),
    .underflow_err(uf_err1));

  fifo_rd_packer #(.IN_W(16), .RATIO(4), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty2), .fifo_underflow(uf2),
    .fifo_data_out(d2), .fifo_rd_en(rd_en2), .flush(flush2), .m_data(m_data2),
    .m_keep(m_keep2), .m_valid(mv2), .m_ready(m_ready2), .busy(busy2),
    .underflow_err(uf_err2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO read-side models: one-cycle and two-cycle read latency.
  always @(posedge clk)
    if (rd_en1 && !fifo_empty1) begin
      d1 <= fq1.pop_front();
      pop_cnt1 <= pop_cnt1 + 1;
    end

  always @(posedge clk) begin
    d2 <= d2a;
    if (rd_en2 && !fifo_empty2) begin
      d2a <= fq2.pop_front();
      pop_cnt2 <= pop_cnt2 + 1;
    end
  end

  function automatic vec_t v(input logic fl, rdy, rd, mv, input logic [31:0] d,
                             input logic [1:0] k, input logic bz);
    v = {fl, rdy, rd, mv, d, k, bz};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push1(input logic [15:0] w);
    fq1.push_back(w);
    push_cnt1++;
  endtask

  task automatic push2(input logic [15:0] w);
    fq2.push_back(w);
    push_cnt2++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush1 = 1'b0; m_ready1 = 1'b0; flush2 = 1'b0; m_ready2 = 1'b0;
    fifo_underflow = 1'b0;
    fq1.delete(); push_cnt1 = pop_cnt1;
    fq2.delete(); push_cnt2 = pop_cnt2;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Entered at a falling edge; applies one row, checks, advances to the next falling edge.
  task automatic run_row(input vec_t r, input string nm, input int idx);
    flush1 = r.fl;
    m_ready1 = r.rdy;
    #1;
    chk($sformatf("%s[%0d].rd_en", nm, idx), rd_en1, r.rd);
    chk($sformatf("%s[%0d].m_valid", nm, idx), mv1, r.mv);
    if (r.mv) begin
      chk($sformatf("%s[%0d].m_data", nm, idx), m_data1, r.d);
      chk($sformatf("%s[%0d].m_keep", nm, idx), m_keep1, r.k);
    end
    chk($sformatf("%s[%0d].busy", nm, idx), busy1, r.bz);
    @(negedge clk);
    flush1 = 1'b0;
  endtask

  task automatic get_beat1(output logic [31:0] d, output bit ok);
    ok = 1'b0;
    d = '0;
    for (int c = 0; c < 40 && !ok; c++) begin
      #1;
      if (mv1 && m_ready1) begin
        d = m_data1;
        ok = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] bd;
    logic [31:0] exp_b[3];
    bit ok;
    int p0, extra;

    errors = 0; checks = 0;
    t1.push_back(v(0,1,1,0,32'h0,2'b00,0));
    t1.push_back(v(0,1,1,0,32'h0,2'b00,1));
    t1.push_back(v(0,1,0,0,32'h0,2'b00,1));
    t1.push_back(v(0,1,1,0,32'h0,2'b00,1));
    t1.push_back(v(0,1,1,1,32'h2222_1111,2'b11,1));
    t1.push_back(v(0,1,0,0,32'h0,2'b00,1));
    t1.push_back(v(0,1,0,0,32'h0,2'b00,1));
    t1.push_back(v(0,1,0,1,32'h4444_3333,2'b11,1));
    t1.push_back(v(0,1,0,0,32'h0,2'b00,0));

    t3.push_back(v(0,1,1,0,32'h0,2'b00,0));
    t3.push_back(v(0,1,0,0,32'h0,2'b00,1));
    t3.push_back(v(1,1,0,0,32'h0,2'b00,1));
    t3.push_back(v(0,1,0,0,32'h0,2'b00,1));
    t3.push_back(v(0,1,0,0,32'h0,2'b00,1));
    t3.push_back(v(0,1,0,1,32'h0000_ABCD,2'b01,1));
    t3.push_back(v(0,1,0,0,32'h0,2'b00,0));
    t3.push_back(v(1,1,0,0,32'h0,2'b00,0));
    t3.push_back(v(0,1,0,0,32'h0,2'b00,1));
    t3.push_back(v(0,1,0,0,32'h0,2'b00,0));

    t4.push_back(v(1,1,1,0,32'h0,2'b00,0));
    t4.push_back(v(0,1,0,0,32'h0,2'b00,1));
    t4.push_back(v(0,1,0,0,32'h0,2'b00,1));
    t4.push_back(v(0,1,0,0,32'h0,2'b00,1));
    t4.push_back(v(0,1,1,1,32'h0000_5A5A,2'b01,1));
    t4.push_back(v(0,1,0,0,32'h0,2'b00,1));

    // Reset state, with a word waiting so rd_en gating is visible.
    rst = 1'b1; flush1 = 0; m_ready1 = 0; flush2 = 0; m_ready2 = 0;
    fifo_underflow = 0; uf2 = 0;
    push1(16'h1234);
    @(negedge clk); #1;
    chk("rst.rd_en", rd_en1, 0);
    chk("rst.m_valid", mv1, 0);
    chk("rst.m_data", m_data1, 0);
    chk("rst.m_keep", m_keep1, 0);
    chk("rst.busy", busy1, 0);
    chk("rst.underflow_err", uf_err1, 0);
    chk("rst.m_valid2", mv2, 0);

    // Two beats back to back with sustained ready.
    do_reset();
    push1(16'h1111); push1(16'h2222); push1(16'h3333); push1(16'h4444);
    foreach (t1[i]) run_row(t1[i], "t1", i);

    // Backpressure: credits stop reads after two beats' worth.
    do_reset();
    p0 = pop_cnt1;
    for (int i = 1; i <= 6; i++) push1(16'h0A00 + 16'(i));
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c >= 5) begin
        chk("t2.hold_valid", mv1, 1);
        chk("t2.hold_data", m_data1, 32'h0A02_0A01);
        chk("t2.hold_keep", m_keep1, 2'b11);
      end
      @(negedge clk);
    end
    chk("t2.reads_stalled", pop_cnt1 - p0, 4);
    m_ready1 = 1'b1;
    exp_b[0] = 32'h0A02_0A01; exp_b[1] = 32'h0A04_0A03; exp_b[2] = 32'h0A06_0A05;
    for (int b = 0; b < 3; b++) begin
      get_beat1(bd, ok);
      chk($sformatf("t2.beat%0d_seen", b), ok, 1);
      chk($sformatf("t2.beat%0d_data", b), bd, exp_b[b]);
    end
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (mv1) extra++;
      @(negedge clk);
    end
    chk("t2.no_extra_beat", extra, 0);
    chk("t2.reads_total", pop_cnt1 - p0, 6);

    // Partial flush, then an empty flush.
    do_reset();
    push1(16'hABCD);
    foreach (t3[i]) run_row(t3[i], "t3", i);

    // Flush alongside a read in flight.
    do_reset();
    push1(16'h5A5A); push1(16'h6B6B);
    foreach (t4[i]) run_row(t4[i], "t4", i);

    // Asynchronous reset mid-beat; first beat afterwards is post-reset data only.
    do_reset();
    for (int i = 1; i <= 3; i++) push1(16'h0B00 + 16'(i));
    repeat (8) @(negedge clk);
    #1;
    chk("t5.pre_valid", mv1, 1);
    chk("t5.pre_busy", busy1, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5.async_m_valid", mv1, 0);
    chk("t5.async_m_data", m_data1, 0);
    chk("t5.async_m_keep", m_keep1, 0);
    chk("t5.async_rd_en", rd_en1, 0);
    chk("t5.async_busy", busy1, 0);
    fq1.delete(); push_cnt1 = pop_cnt1;
    @(negedge clk);
    rst = 1'b0;
    push1(16'h0C01); push1(16'h0C02);
    m_ready1 = 1'b1;
    get_beat1(bd, ok);
    chk("t5.post_seen", ok, 1);
    chk("t5.post_data", bd, 32'h0C02_0C01);

    // Sticky underflow flag.
    fifo_underflow = 1'b1;
    #1;
    chk("t6.uf_before_edge", uf_err1, 0);
    @(negedge clk);
    fifo_underflow = 1'b0;
    #1;
    chk("t6.uf_set", uf_err1, 1);
    repeat (4) @(negedge clk);
    #1;
    chk("t6.uf_sticky", uf_err1, 1);
    do_reset();
    #1;
    chk("t6.uf_cleared", uf_err1, 0);
    @(negedge clk);

    // Wide configuration: four words per beat, two-cycle read latency.
    push2(16'h1111); push2(16'h2222); push2(16'h3333); push2(16'h4444);
    m_ready2 = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      #1;
      if (mv2) begin
        ok = 1'b1;
        chk("t6w.m_data", m_data2, 64'h4444_3333_2222_1111);
        chk("t6w.m_keep", m_keep2, 4'hF);
      end
      @(negedge clk);
    end
    chk("t6w.beat_seen", ok, 1);
    for (int c = 0; c < 10 && busy2; c++) @(negedge clk);
    #1;
    chk("t6w.busy_idle", busy2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
